// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier that retires one multiplier bit per clock.
//   It produces a 2*WIDTH-bit product of two WIDTH-bit operands, either
//   unsigned or two's-complement, selected for each operation.
//   The operands are reduced to magnitudes when the operation starts. The sign
//   is applied to the accumulated product on the final iteration.
//
//   Parameters
//     WIDTH      operand width in bits (>= 2); result is 2*WIDTH bits
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     load       start request; a, b, is_signed are sampled on the same edge
//     is_signed  1: two's-complement operands, 0: unsigned
//     a          multiplicand
//     b          multiplier
//     result     product; held stable while valid = 1
//     valid      result ready; stays high until the next accepted load
//     busy       high while iterating; load is ignored while busy
//
//   Build option
//     MUL_EARLY_EXIT_EN  finish as soon as the remaining multiplier bits are
//                        all zero (latency = 1 + index of highest set bit of |b|,
//                        minimum 1 cycle). Products are unchanged.
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 valid,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mplier_shr;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic                 accept;
    logic                 last_iter;

    // The magnitude of the most negative value, 2^(WIDTH-1), still fits in an
    // unsigned WIDTH-bit register, so no extra bit is needed.
    always_comb begin
        accept     = load && (state != RUN);
        a_mag      = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag      = (is_signed && b[WIDTH-1]) ? -b : b;
        acc_sum    = mplier[0] ? (acc + mcand) : acc;
        mplier_shr = mplier >> 1;
`ifdef MUL_EARLY_EXIT_EN
        // Once the bits left to process are all zero, the remaining
        // iterations cannot change the accumulator.
        last_iter  = (cnt == CNT_W'(WIDTH - 1)) || (mplier_shr == '0);
`else
        last_iter  = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    if (accept)    state_next = RUN;
            default:                state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
            valid  <= 1'b0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            valid  <= 1'b0;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier_shr;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
                result <= neg ? -acc_sum : acc_sum;
                valid  <= 1'b1;
            end
        end
    end

endmodule
